// File: rtl/airlock_pkg.sv
// airlock_pkg: shared types and default timing for the airlock interlock controller.
package airlock_pkg;

  // Chamber state: two stable pressures and the two pump cycles between them.
  typedef enum logic [1:0] {
    ST_EVACUATED   = 2'd0,
    ST_FILLING     = 2'd1,
    ST_PRESSURIZED = 2'd2,
    ST_EVACUATING  = 2'd3
  } airlock_state_e;

  // Default timing: board clock divided into countdown ticks.
  localparam int DEF_TICK_DIV  = 4;
  localparam int DEF_FILL_SECS = 7;
  localparam int DEF_EVAC_SECS = 8;
  localparam int DEF_CNT_W     = 10;

  // Number of command pulses raised in the same cycle.
  function automatic logic [2:0] cmd_count(input logic [4:0] cmds);
    logic [2:0] c;
    c = '0;
    for (int k = 0; k < 5; k++) begin
      c = c + {2'b00, cmds[k]};
    end
    return c;
  endfunction

endpackage

// File: rtl/airlock_controller_tick_prescaler.sv
// tick_prescaler: divides the clock into a one-cycle tick every TICK_DIV enabled cycles.
// The counter is forced to 0 while clear_i is high so a new cycle always starts a full tick period.
module tick_prescaler
  import airlock_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // Next prescaler value: clear wins, otherwise wrap at LAST while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = enable_i & (cnt_q == LAST);

endmodule

// File: rtl/airlock_controller.sv
// airlock_controller: interlocked FSM for a single chamber with inner/outer doors,
// timed fill and evacuate cycles, and a tick countdown for the display.
// Optional feature macro: AIRLOCK_ABORT_EN (abort reverses a running pump cycle).
module airlock_controller
  import airlock_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int FILL_SECS = DEF_FILL_SECS,
  parameter int EVAC_SECS = DEF_EVAC_SECS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fill_req_i,
  input  logic             evac_req_i,
  input  logic             inner_toggle_i,
  input  logic             outer_toggle_i,
  input  logic             abort_i,
  output logic             inner_open_o,
  output logic             outer_open_o,
  output logic             pressurized_o,
  output logic             evacuated_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] countdown_o,
  output logic             done_o,
  output logic             cmd_err_o
);

`ifdef AIRLOCK_ABORT_EN
  localparam logic ABORT_EN = 1'b1;
`else
  localparam logic ABORT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] FILL_CNT = CNT_W'(FILL_SECS);
  localparam logic [CNT_W-1:0] EVAC_CNT = CNT_W'(EVAC_SECS);

  airlock_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inner_q, inner_d;
  logic             outer_q, outer_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             busy;
  logic             tick;
  logic             pre_clr;
  logic             abort_v;
  logic [2:0]       ncmd;

  // Without the feature the abort pulse is masked so it neither acts nor counts as a command.
  assign abort_v = abort_i & ABORT_EN;
  assign ncmd    = cmd_count({fill_req_i, evac_req_i, inner_toggle_i, outer_toggle_i, abort_v});
  assign busy    = (state_q == ST_FILLING) || (state_q == ST_EVACUATING);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (pre_clr | ~busy),
    .enable_i(busy),
    .tick_o  (tick)
  );

  // Next-state, countdown, door and pulse logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inner_d = inner_q;
    outer_d = outer_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    pre_clr = 1'b0;

    unique case (state_q)
      ST_EVACUATED: begin
        if (ncmd > 3'd1) begin
          err_d = 1'b1;
        end else if (ncmd == 3'd1) begin
          if (outer_toggle_i) begin
            outer_d = ~outer_q;
          end else if (fill_req_i && !outer_q && !inner_q) begin
            state_d = ST_FILLING;
            cnt_d   = FILL_CNT;
            pre_clr = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_PRESSURIZED: begin
        if (ncmd > 3'd1) begin
          err_d = 1'b1;
        end else if (ncmd == 3'd1) begin
          if (inner_toggle_i) begin
            inner_d = ~inner_q;
          end else if (evac_req_i && !inner_q && !outer_q) begin
            state_d = ST_EVACUATING;
            cnt_d   = EVAC_CNT;
            pre_clr = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: begin
`ifdef AIRLOCK_ABORT_EN
        if ((ncmd == 3'd1) && abort_v) begin
          // Reverse: the new cycle lasts as long as the old one has already run.
          if (state_q == ST_FILLING) begin
            if (cnt_q >= FILL_CNT) begin
              state_d = ST_EVACUATED;
              cnt_d   = '0;
            end else begin
              state_d = ST_EVACUATING;
              cnt_d   = FILL_CNT - cnt_q;
              pre_clr = 1'b1;
            end
          end else begin
            if (cnt_q >= EVAC_CNT) begin
              state_d = ST_PRESSURIZED;
              cnt_d   = '0;
            end else begin
              state_d = ST_FILLING;
              cnt_d   = EVAC_CNT - cnt_q;
              pre_clr = 1'b1;
            end
          end
        end else
`endif
        begin
          if (ncmd != 3'd0) begin
            err_d = 1'b1;
          end
          if (tick) begin
            if (cnt_q == CNT_W'(1)) begin
              cnt_d   = '0;
              done_d  = 1'b1;
              state_d = (state_q == ST_FILLING) ? ST_PRESSURIZED : ST_EVACUATED;
            end else if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
      end
    endcase
  end

  // State, countdown, doors and pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EVACUATED;
      cnt_q   <= '0;
      inner_q <= 1'b0;
      outer_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inner_q <= inner_d;
      outer_q <= outer_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign inner_open_o  = inner_q;
  assign outer_open_o  = outer_q;
  assign pressurized_o = (state_q == ST_PRESSURIZED);
  assign evacuated_o   = (state_q == ST_EVACUATED);
  assign busy_o        = busy;
  assign countdown_o   = cnt_q;
  assign done_o        = done_q;
  assign cmd_err_o     = err_q;

endmodule

// File: tb/tb_airlock_controller.sv
// tb_airlock_controller: directed stimulus with a time-based behavioural model of the airlock
// and a per-cycle comparison of every output, plus hand-computed literal expectations.
module tb_airlock_controller;

  localparam int TD = 4;
  localparam int FS = 3;
  localparam int ES = 2;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          fill_req_i = 1'b0;
  logic          evac_req_i = 1'b0;
  logic          inner_toggle_i = 1'b0;
  logic          outer_toggle_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          inner_open_o;
  logic          outer_open_o;
  logic          pressurized_o;
  logic          evacuated_o;
  logic          busy_o;
  logic [CW-1:0] countdown_o;
  logic          done_o;
  logic          cmd_err_o;

  airlock_controller #(
    .TICK_DIV (TD),
    .FILL_SECS(FS),
    .EVAC_SECS(ES),
    .CNT_W    (CW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .fill_req_i    (fill_req_i),
    .evac_req_i    (evac_req_i),
    .inner_toggle_i(inner_toggle_i),
    .outer_toggle_i(outer_toggle_i),
    .abort_i       (abort_i),
    .inner_open_o  (inner_open_o),
    .outer_open_o  (outer_open_o),
    .pressurized_o (pressurized_o),
    .evacuated_o   (evacuated_o),
    .busy_o        (busy_o),
    .countdown_o   (countdown_o),
    .done_o        (done_o),
    .cmd_err_o     (cmd_err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Model: 0 = at vacuum, 1 = at pressure, 2 = pumping for m_dur ticks, m_age clocks in.
  int m_mode;
  bit m_to_press;
  int m_dur;
  int m_age;
  bit m_inner, m_outer, m_done, m_err;

  function automatic int m_cd();
    return (m_mode == 2) ? (m_dur - m_age / TD) : 0;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_to_press = 1'b0; m_dur = 0; m_age = 0;
    m_inner = 1'b0; m_outer = 1'b0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_start(input bit to_press, input int secs);
    m_mode = 2; m_to_press = to_press; m_dur = secs; m_age = 0;
  endtask

  task automatic model_step(input bit f, input bit e, input bit i, input bit o, input bit a);
    int n;
    int secs;
    int el;
    bit ab;
`ifdef AIRLOCK_ABORT_EN
    ab = a;
`else
    ab = 1'b0;
`endif
    n = int'(f) + int'(e) + int'(i) + int'(o) + int'(ab);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (m_mode == 2) begin
      if (n == 1 && ab) begin
        secs = m_to_press ? FS : ES;
        el = secs - m_cd();
        if (el < 0) el = 0;
        if (el == 0) m_mode = m_to_press ? 0 : 1;
        else model_start(!m_to_press, el);
      end else begin
        if (n != 0) m_err = 1'b1;
        m_age++;
        if (m_age == m_dur * TD) begin
          m_mode = m_to_press ? 1 : 0;
          m_done = 1'b1;
        end
      end
    end else if (n > 1) begin
      m_err = 1'b1;
    end else if (n == 1) begin
      if (m_mode == 0) begin
        if (o) m_outer = !m_outer;
        else if (f && !m_outer) model_start(1'b1, FS);
        else m_err = 1'b1;
      end else begin
        if (i) m_inner = !m_inner;
        else if (e && !m_inner) model_start(1'b0, ES);
        else m_err = 1'b1;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("inner_open", int'(inner_open_o), int'(m_inner));
      chk("outer_open", int'(outer_open_o), int'(m_outer));
      chk("pressurized", int'(pressurized_o), int'(m_mode == 1));
      chk("evacuated", int'(evacuated_o), int'(m_mode == 0));
      chk("busy", int'(busy_o), int'(m_mode == 2));
      chk("countdown", int'(countdown_o), m_cd());
      chk("done", int'(done_o), int'(m_done));
      chk("cmd_err", int'(cmd_err_o), int'(m_err));
    end
  end

  task automatic cyc(input bit f, input bit e, input bit i, input bit o, input bit a);
    fill_req_i = f; evac_req_i = e; inner_toggle_i = i; outer_toggle_i = o; abort_i = a;
    @(posedge clk);
    model_step(f, e, i, o, a);
    #1;
    fill_req_i = 1'b0; evac_req_i = 1'b0; inner_toggle_i = 1'b0;
    outer_toggle_i = 1'b0; abort_i = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #2;
    rst_ni = 1'b1;
    chk("rst_evacuated", int'(evacuated_o), 1);
    chk("rst_pressurized", int'(pressurized_o), 0);
    chk("rst_doors", int'({inner_open_o, outer_open_o}), 0);
    chk("rst_countdown", int'(countdown_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    check_en = 1'b1;

    // Fill: 3 ticks of 4 clocks, completes 12 clocks after acceptance.
    cyc(1, 0, 0, 0, 0);
    chk("fill_busy", int'(busy_o), 1);
    chk("fill_cd3", int'(countdown_o), 3);
    idle(4);
    chk("fill_cd2", int'(countdown_o), 2);
    idle(4);
    chk("fill_cd1", int'(countdown_o), 1);
    idle(3);
    chk("fill_busy_e11", int'(busy_o), 1);
    idle(1);
    chk("fill_press", int'(pressurized_o), 1);
    chk("fill_done", int'(done_o), 1);
    chk("fill_cd0", int'(countdown_o), 0);
    idle(1);
    chk("done_one_cycle", int'(done_o), 0);

    // Pressurized: inner door open blocks evacuation.
    cyc(0, 0, 1, 0, 0);
    chk("inner_open", int'(inner_open_o), 1);
    cyc(0, 1, 0, 0, 0);
    chk("evac_door_err", int'(cmd_err_o), 1);
    chk("evac_door_stay", int'(pressurized_o), 1);
    cyc(0, 0, 1, 0, 0);
    chk("inner_closed", int'(inner_open_o), 0);
    cyc(0, 1, 0, 0, 0);
    chk("evac_cd2", int'(countdown_o), 2);
    idle(7);
    chk("evac_busy_e7", int'(busy_o), 1);
    idle(1);
    chk("evac_done", int'(done_o), 1);
    chk("evac_evacuated", int'(evacuated_o), 1);

    // Evacuated: simultaneous commands, outer door interlock, wrong-state command.
    cyc(1, 0, 0, 1, 0);
    chk("multi_err", int'(cmd_err_o), 1);
    chk("multi_outer", int'(outer_open_o), 0);
    chk("multi_busy", int'(busy_o), 0);
    cyc(0, 0, 0, 1, 0);
    chk("outer_open", int'(outer_open_o), 1);
    cyc(1, 0, 0, 0, 0);
    chk("fill_door_err", int'(cmd_err_o), 1);
    chk("fill_door_busy", int'(busy_o), 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    chk("inner_in_vac_err", int'(cmd_err_o), 1);
    chk("inner_in_vac", int'(inner_open_o), 0);

    // Door toggles during a fill are rejected; schedule unchanged.
    cyc(1, 0, 0, 0, 0);
    idle(4);
    chk("busy_cd2", int'(countdown_o), 2);
    cyc(0, 0, 0, 1, 0);
    chk("busy_outer_err", int'(cmd_err_o), 1);
    chk("busy_outer_closed", int'(outer_open_o), 0);
    cyc(0, 0, 1, 0, 0);
    chk("busy_inner_err", int'(cmd_err_o), 1);
    idle(5);
    chk("busy_sched_e11", int'(busy_o), 1);
    idle(1);
    chk("busy_sched_done", int'(done_o), 1);
    cyc(0, 1, 0, 0, 0);
    idle(8);
    chk("back_vac", int'(evacuated_o), 1);

`ifdef AIRLOCK_ABORT_EN
    cyc(1, 0, 0, 0, 0);
    idle(4);
    cyc(0, 0, 0, 0, 1);
    chk("abort_busy", int'(busy_o), 1);
    chk("abort_cd1", int'(countdown_o), 1);
    chk("abort_press", int'(pressurized_o), 0);
    idle(3);
    chk("abort_busy_e3", int'(busy_o), 1);
    idle(1);
    chk("abort_vac", int'(evacuated_o), 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("abort0_vac", int'(evacuated_o), 1);
    chk("abort0_done", int'(done_o), 0);
    chk("abort0_busy", int'(busy_o), 0);
    idle(2);
    cyc(0, 0, 0, 0, 1);
    chk("abort_stable_err", int'(cmd_err_o), 1);
`else
    cyc(0, 0, 0, 0, 1);
    chk("abort_ignored", int'(cmd_err_o), 0);
    cyc(1, 0, 0, 0, 1);
    chk("abort_not_counted", int'(busy_o), 1);
    idle(12);
    chk("abort_fill_press", int'(pressurized_o), 1);
    cyc(0, 1, 0, 0, 0);
    idle(8);
`endif

    // Asynchronous reset in the middle of an evacuation.
    cyc(1, 0, 0, 0, 0);
    idle(12);
    cyc(0, 1, 0, 0, 0);
    idle(3);
    chk("pre_rst_busy", int'(busy_o), 1);
    check_en = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_evacuated", int'(evacuated_o), 1);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_countdown", int'(countdown_o), 0);
    chk("arst_pressurized", int'(pressurized_o), 0);
    chk("arst_pulses", int'({done_o, cmd_err_o}), 0);
    @(negedge clk);
    #2;
    rst_ni = 1'b1;
    model_reset();
    check_en = 1'b1;
    idle(3);
    chk("post_rst_vac", int'(evacuated_o), 1);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
